// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Steps through a note ROM of {index, duration} entries, times
//                each note in tempo ticks, and drives a one-hot note bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
  parameter int TICK_DIV  = 2500000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W    = 6
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [12:0]       rom_data,
  output logic [31:0]       note_out,
  output logic              playing,
  output logic              done
);

  localparam int c_tick_w = $clog2(TICK_DIV);
  localparam int c_gap_w  = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_NOTE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [ADDR_W-1:0]   r_len, w_len_nxt;
  logic [31:0]         r_note, w_note_nxt;
  logic                r_done, w_done_nxt;
  logic [7:0]          r_dur, w_dur_nxt;
  logic [c_gap_w-1:0]  r_gap, w_gap_nxt;
  logic [c_tick_w-1:0] r_tick, w_tick_nxt;
  logic                w_tick, w_last, w_advance;
  logic [31:0]         w_note_dec;

  assign w_tick     = (r_tick == c_tick_last);
  assign w_last     = (r_addr == (r_len - ADDR_W'(1)));
  // Indices 30 and 31 are rests: timed like a note but silent.
  assign w_note_dec = (rom_data[12:8] < 5'd30) ? (32'd1 << rom_data[12:8]) : 32'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_note_nxt  = r_note;
    w_done_nxt  = 1'b0;
    w_dur_nxt   = r_dur;
    w_gap_nxt   = r_gap;
    w_tick_nxt  = r_tick;
    w_advance   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop && (song_len != '0)) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_len_nxt   = song_len;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (rom_data[7:0] == 8'd0) begin
          w_advance = 1'b1;
        end else begin
          w_dur_nxt   = rom_data[7:0];
          w_tick_nxt  = '0;
          w_note_nxt  = w_note_dec;
          w_state_nxt = S_NOTE;
        end
      end
      S_NOTE: begin
        if (w_tick) begin
          w_tick_nxt = '0;
          w_dur_nxt  = r_dur - 8'd1;
          if (r_dur == 8'd1) begin
            w_note_nxt = '0;
            if (GAP_TICKS == 0) begin
              w_advance = 1'b1;
            end else begin
              w_gap_nxt   = c_gap_load;
              w_state_nxt = S_GAP;
            end
          end
        end else begin
          w_tick_nxt = r_tick + c_tick_w'(1);
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_tick_nxt = '0;
          w_gap_nxt  = r_gap - c_gap_w'(1);
          if (r_gap == c_gap_w'(1)) w_advance = 1'b1;
        end else begin
          w_tick_nxt = r_tick + c_tick_w'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_advance) begin
      if (!w_last) begin
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_state_nxt = S_FETCH;
      end else if (loop_en) begin
        w_addr_nxt  = '0;
        w_state_nxt = S_FETCH;
      end else begin
        w_addr_nxt  = '0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end

    // Abort overrides everything, including a same-cycle song completion.
    if (stop && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_note_nxt  = '0;
      w_addr_nxt  = '0;
      w_tick_nxt  = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_note  <= '0;
      r_done  <= 1'b0;
      r_dur   <= '0;
      r_gap   <= '0;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_len   <= w_len_nxt;
      r_note  <= w_note_nxt;
      r_done  <= w_done_nxt;
      r_dur   <= w_dur_nxt;
      r_gap   <= w_gap_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign rom_addr = r_addr;
  assign note_out = r_note;
  assign done     = r_done;
  assign playing  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_sequencer
//  Description : Directed self-checking bench for melody_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [5:0]  song_len;
  logic [5:0]  rom_addr;
  logic [12:0] rom_data;
  logic [31:0] note_out;
  logic        playing;
  logic        done;

  logic [12:0] rom [0:63];
  int          n_checks;
  int          n_errors;

  melody_sequencer #(
    .TICK_DIV  (4),
    .GAP_TICKS (1),
    .ADDR_W    (6)
  ) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .song_len (song_len),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note_out (note_out),
    .playing  (playing),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Song {(0,2),(5,1)}; k = sample index after the edge that accepted start.
  task automatic play1(input int nk, input bit lp);
    logic [31:0] en;
    logic        ep, ed;
    int          kk;
    start = 1'b1;
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      start = 1'b0;
      kk = (lp && k >= 24) ? (k % 24) : k;
      en = (kk >= 2 && kk <= 9) ? 32'h1 : ((kk >= 16 && kk <= 19) ? 32'h20 : 32'h0);
      ep = lp ? 1'b1 : (k <= 23);
      ed = !lp && (k == 24);
      chk($sformatf("s1 note k%0d", k), note_out, en);
      chk($sformatf("s1 play k%0d", k), {31'd0, playing}, {31'd0, ep});
      chk($sformatf("s1 done k%0d", k), {31'd0, done}, {31'd0, ed});
      if (lp && k == 24) chk("s1 loop addr", {26'd0, rom_addr}, 32'd0);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s play %0d", tag, k), {31'd0, playing}, 32'd0);
      chk($sformatf("%s done %0d", tag, k), {31'd0, done}, 32'd0);
      chk($sformatf("%s addr %0d", tag, k), {26'd0, rom_addr}, 32'd0);
      chk($sformatf("%s note %0d", tag, k), note_out, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] en;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    song_len = 6'd2;
    for (int i = 0; i < 64; i++) rom[i] = 13'd0;
    rom[0] = {5'd0, 8'd2};
    rom[1] = {5'd5, 8'd1};
    repeat (3) @(negedge clk);
    chk("rst play", {31'd0, playing}, 32'd0);
    chk("rst note", note_out, 32'd0);
    chk("rst addr", {26'd0, rom_addr}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single non-looping play-through with done pulse.
    play1(27, 1'b0);
    idle_check("post1", 2);

    // Looping: wraps to entry 0, done never pulses.
    loop_en = 1'b1;
    play1(40, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop    = 1'b0;
    loop_en = 1'b0;
    chk("loop stop play", {31'd0, playing}, 32'd0);
    chk("loop stop done", {31'd0, done}, 32'd0);
    idle_check("post2", 2);

    // Stop during first note, then a full replay from entry 0.
    play1(5, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop note", note_out, 32'd0);
    chk("stop play", {31'd0, playing}, 32'd0);
    chk("stop done", {31'd0, done}, 32'd0);
    chk("stop addr", {26'd0, rom_addr}, 32'd0);
    idle_check("post3", 2);
    play1(26, 1'b0);

    // Zero-duration skip, rest entry, and the top playable index.
    rom[0]   = {5'd3, 8'd0};
    rom[1]   = {5'd31, 8'd3};
    rom[2]   = {5'd29, 8'd1};
    song_len = 6'd3;
    start    = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      start = 1'b0;
      en = (k >= 22 && k <= 25) ? 32'h2000_0000 : 32'h0;
      chk($sformatf("s4 note k%0d", k), note_out, en);
      chk($sformatf("s4 play k%0d", k), {31'd0, playing}, {31'd0, (k <= 29)});
      chk($sformatf("s4 done k%0d", k), {31'd0, done}, {31'd0, (k == 30)});
      if (k == 2)  chk("s4 skip addr", {26'd0, rom_addr}, 32'd1);
      if (k == 20) chk("s4 addr2", {26'd0, rom_addr}, 32'd2);
    end

    // Asynchronous reset mid-note, then start and stop together.
    rom[0]   = {5'd0, 8'd2};
    rom[1]   = {5'd5, 8'd1};
    song_len = 6'd2;
    play1(6, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst note", note_out, 32'd0);
    chk("arst play", {31'd0, playing}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    idle_check("ststp", 3);

    // Empty song: start is ignored.
    song_len = 6'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0 play", {31'd0, playing}, 32'd0);
    idle_check("len0", 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
